// File: rtl/text_pkg.sv
// Shared types and constants for the text executor: opcodes, FSM states, cell layout.
// The scroll states exist only when TEXT_SCROLL_EN is defined.
package text_pkg;

   localparam logic [7:0] TEXT_WRITE    = 8'h00;
   localparam logic [7:0] TEXT_POSITION = 8'h01;
   localparam logic [7:0] TEXT_CLEAR    = 8'h02;
   localparam logic [7:0] GET_TEXT_AT   = 8'h03;

   localparam logic [7:0] CHAR_LF     = 8'h0A;
   localparam logic [7:0] CHAR_CR     = 8'h0D;
   localparam logic [7:0] SCROLL_ATTR = 8'h0F;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WRITE,
      ST_CLEAR,
      ST_RD_ADDR,
      ST_RD_CAP,
`ifdef TEXT_SCROLL_EN
      ST_SCRL_RD,
      ST_SCRL_WR,
      ST_SCRL_BLANK,
`endif
      ST_DONE,
      ST_ERR
   } state_e;

   typedef enum logic [2:0] {
      CUR_NONE,
      CUR_ADVANCE,
      CUR_NEWLINE,
      CUR_CR,
      CUR_SET,
      CUR_HOME
   } cursor_cmd_e;

   typedef struct packed {
      logic [7:0] attr;
      logic [7:0] chr;
   } cell_t;

   function automatic cell_t make_cell(input logic [7:0] attr, input logic [7:0] chr);
      cell_t c;
      c.attr = attr;
      c.chr  = chr;
      return c;
   endfunction

endpackage

// File: rtl/text_cursor.sv
// Text cursor registers with advance / newline / CR / set / home commands.
// With TEXT_SCROLL_EN the cursor parks on the last row instead of wrapping to row 0.
module text_cursor
   import text_pkg::*;
#(
   parameter int COLS = 80,
   parameter int ROWS = 30
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [2:0] cmd_i,
   input  logic [6:0] col_i,
   input  logic [4:0] row_i,
`ifdef TEXT_SCROLL_EN
   output logic       wrap_last_row_o,
`endif
   output logic [6:0] col_o,
   output logic [4:0] row_o
);

   logic [6:0] col_q, col_d;
   logic [4:0] row_q, row_d;
   logic       last_col;
   logic       last_row;
   logic [4:0] row_next;

   assign last_col = (col_q == 7'(COLS - 1));
   assign last_row = (row_q == 5'(ROWS - 1));

`ifdef TEXT_SCROLL_EN
   assign row_next = last_row ? 5'(ROWS - 1) : row_q + 5'd1;
   assign wrap_last_row_o = last_row &&
                            ((cmd_i == CUR_ADVANCE && last_col) || cmd_i == CUR_NEWLINE);
`else
   assign row_next = last_row ? 5'd0 : row_q + 5'd1;
`endif

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      case (cmd_i)
         CUR_ADVANCE: begin
            if (last_col) begin
               col_d = '0;
               row_d = row_next;
            end else begin
               col_d = col_q + 7'd1;
            end
         end
         CUR_NEWLINE: begin
            col_d = '0;
            row_d = row_next;
         end
         CUR_CR:   col_d = '0;
         CUR_SET: begin
            col_d = col_i;
            row_d = row_i;
         end
         CUR_HOME: begin
            col_d = '0;
            row_d = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col_o = col_q;
   assign row_o = row_q;

endmodule

// File: rtl/text_executor.sv
// Executes TEXT_WRITE / TEXT_POSITION / TEXT_CLEAR / GET_TEXT_AT against the text VRAM port.
// Define TEXT_SCROLL_EN to scroll the screen up instead of wrapping the cursor to row 0.
module text_executor
   import text_pkg::*;
#(
   parameter int         COLS       = 80,
   parameter int         ROWS       = 30,
   parameter int         ADDR_W     = 12,
   parameter logic [7:0] BLANK_CHAR = 8'h20
) (
   input  logic              phi2,
   input  logic              reset_n,
   input  logic [7:0]        instruction,
   input  logic [7:0]        arg_0,
   input  logic [7:0]        arg_1,
   input  logic              instruction_start,
   output logic              instruction_busy,
   output logic              instruction_finished,
   output logic              instruction_error,
   output logic [7:0]        result_0,
   output logic [7:0]        result_1,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [15:0]       vram_wdata,
   output logic              vram_we,
   input  logic [15:0]       vram_rdata,
   output logic [6:0]        cursor_col,
   output logic [4:0]        cursor_row
);

   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
`ifdef TEXT_SCROLL_EN
   localparam logic [ADDR_W-1:0] LAST_SRC = ADDR_W'(COLS * (ROWS - 1) - 1);
   localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
   logic wrap_last_row;
`endif

   state_e            state_q, state_d;
   logic [7:0]        attr_q, attr_d;
   logic [7:0]        char_q, char_d;
   logic [6:0]        tcol_q, tcol_d;
   logic [4:0]        trow_q, trow_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [7:0]        res0_q, res0_d;
   logic [7:0]        res1_q, res1_d;
   cursor_cmd_e       cur_cmd;
   logic              in_range;
   logic              is_ctrl;

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] col, input logic [4:0] row);
      return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
   endfunction

   assign in_range = (arg_0 < 8'(COLS)) && (arg_1 < 8'(ROWS));
   assign is_ctrl  = (char_q == CHAR_LF) || (char_q == CHAR_CR);

   text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
      .clk_i           (phi2),
      .rst_ni          (reset_n),
      .cmd_i           (cur_cmd),
      .col_i           (arg_0[6:0]),
      .row_i           (arg_1[4:0]),
`ifdef TEXT_SCROLL_EN
      .wrap_last_row_o (wrap_last_row),
`endif
      .col_o           (cursor_col),
      .row_o           (cursor_row)
   );

   // Kept apart from the FSM block: the scroll decision reads the cursor's reaction to this command.
   always_comb begin
      cur_cmd = CUR_NONE;
      case (state_q)
         ST_IDLE:
            if (instruction_start && instruction == TEXT_POSITION && in_range) cur_cmd = CUR_SET;
         ST_WRITE: begin
            if (char_q == CHAR_LF)      cur_cmd = CUR_NEWLINE;
            else if (char_q == CHAR_CR) cur_cmd = CUR_CR;
            else                        cur_cmd = CUR_ADVANCE;
         end
         ST_CLEAR:
            if (ptr_q == LAST_CELL) cur_cmd = CUR_HOME;
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      attr_d     = attr_q;
      char_d     = char_q;
      tcol_d     = tcol_q;
      trow_d     = trow_q;
      ptr_d      = ptr_q;
      res0_d     = res0_q;
      res1_d     = res1_q;
      vram_addr  = '0;
      vram_wdata = '0;
      vram_we    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (instruction_start) begin
               case (instruction)
                  TEXT_WRITE: begin
                     attr_d  = arg_0;
                     char_d  = arg_1;
                     state_d = ST_WRITE;
                  end
                  TEXT_POSITION: state_d = in_range ? ST_DONE : ST_ERR;
                  TEXT_CLEAR: begin
                     attr_d  = arg_0;
                     ptr_d   = '0;
                     state_d = ST_CLEAR;
                  end
                  GET_TEXT_AT: begin
                     tcol_d  = arg_0[6:0];
                     trow_d  = arg_1[4:0];
                     state_d = in_range ? ST_RD_ADDR : ST_ERR;
                  end
                  default: ;
               endcase
            end
         end
         ST_WRITE: begin
            vram_addr  = cell_addr(cursor_col, cursor_row);
            vram_wdata = make_cell(attr_q, char_q);
            vram_we    = !is_ctrl;
            state_d    = ST_DONE;
`ifdef TEXT_SCROLL_EN
            if (wrap_last_row) begin
               ptr_d   = '0;
               state_d = ST_SCRL_RD;
            end
`endif
         end
         ST_CLEAR: begin
            vram_addr  = ptr_q;
            vram_wdata = make_cell(attr_q, BLANK_CHAR);
            vram_we    = 1'b1;
            ptr_d      = ptr_q + ADDR_W'(1);
            if (ptr_q == LAST_CELL) state_d = ST_DONE;
         end
         ST_RD_ADDR: begin
            vram_addr = cell_addr(tcol_q, trow_q);
            state_d   = ST_RD_CAP;
         end
         ST_RD_CAP: begin
            res0_d  = vram_rdata[7:0];
            res1_d  = vram_rdata[15:8];
            state_d = ST_DONE;
         end
`ifdef TEXT_SCROLL_EN
         // Read the cell one row below, then write it back one row up on the next cycle.
         ST_SCRL_RD: begin
            vram_addr = ptr_q + COLS_A;
            state_d   = ST_SCRL_WR;
         end
         ST_SCRL_WR: begin
            vram_addr  = ptr_q;
            vram_wdata = vram_rdata;
            vram_we    = 1'b1;
            ptr_d      = ptr_q + ADDR_W'(1);
            state_d    = (ptr_q == LAST_SRC) ? ST_SCRL_BLANK : ST_SCRL_RD;
         end
         ST_SCRL_BLANK: begin
            vram_addr  = ptr_q;
            vram_wdata = make_cell(SCROLL_ATTR, BLANK_CHAR);
            vram_we    = 1'b1;
            ptr_d      = ptr_q + ADDR_W'(1);
            if (ptr_q == LAST_CELL) state_d = ST_DONE;
         end
`endif
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge phi2 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         attr_q  <= '0;
         char_q  <= '0;
         tcol_q  <= '0;
         trow_q  <= '0;
         ptr_q   <= '0;
         res0_q  <= '0;
         res1_q  <= '0;
      end else begin
         state_q <= state_d;
         attr_q  <= attr_d;
         char_q  <= char_d;
         tcol_q  <= tcol_d;
         trow_q  <= trow_d;
         ptr_q   <= ptr_d;
         res0_q  <= res0_d;
         res1_q  <= res1_d;
      end
   end

   assign instruction_busy     = (state_q != ST_IDLE);
   assign instruction_finished = (state_q == ST_DONE);
   assign instruction_error    = (state_q == ST_ERR);
   assign result_0             = res0_q;
   assign result_1             = res1_q;

endmodule

// File: tb/tb_text_executor.sv
// Self-checking bench for text_executor: directed scenarios plus randomized ops against a screen model.
module tb_text_executor;

   localparam int COLS  = 80;
   localparam int ROWS  = 30;
   localparam int CELLS = COLS * ROWS;
`ifdef TEXT_SCROLL_EN
   localparam bit SCROLL = 1'b1;
`else
   localparam bit SCROLL = 1'b0;
`endif

   logic        phi2;
   logic        reset_n;
   logic [7:0]  instruction;
   logic [7:0]  arg_0;
   logic [7:0]  arg_1;
   logic        instruction_start;
   logic        instruction_busy;
   logic        instruction_finished;
   logic        instruction_error;
   logic [7:0]  result_0;
   logic [7:0]  result_1;
   logic [11:0] vram_addr;
   logic [15:0] vram_wdata;
   logic        vram_we;
   logic [15:0] vram_rdata;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;

   text_executor dut (
      .phi2                 (phi2),
      .reset_n              (reset_n),
      .instruction          (instruction),
      .arg_0                (arg_0),
      .arg_1                (arg_1),
      .instruction_start    (instruction_start),
      .instruction_busy     (instruction_busy),
      .instruction_finished (instruction_finished),
      .instruction_error    (instruction_error),
      .result_0             (result_0),
      .result_1             (result_1),
      .vram_addr            (vram_addr),
      .vram_wdata           (vram_wdata),
      .vram_we              (vram_we),
      .vram_rdata           (vram_rdata),
      .cursor_col           (cursor_col),
      .cursor_row           (cursor_row)
   );

   initial phi2 = 1'b0;
   always #5 phi2 = ~phi2;

   // Text VRAM: synchronous write, registered read.
   logic [15:0] mem [0:4095];
   always @(posedge phi2) begin
      if (vram_we) mem[vram_addr] <= vram_wdata;
      vram_rdata <= mem[vram_addr];
   end

   // Reference model state
   logic [15:0] exp_mem [0:CELLS-1];
   int          mc, mr;
   logic [7:0]  m_res0, m_res1;

   int checks, errors;
   int fin_total, err_total, busy_total, both_total;
   int          wa_q[$];
   logic [15:0] wd_q[$];

   always @(negedge phi2) begin
      if (reset_n) begin
         if (instruction_busy) busy_total++;
         if (instruction_finished) fin_total++;
         if (instruction_error) err_total++;
         if (instruction_finished && instruction_error) both_total++;
         if (vram_we) begin
            wa_q.push_back(int'(vram_addr));
            wd_q.push_back(vram_wdata);
         end
      end
   end

   // Screen model of one TEXT_WRITE; returns the number of VRAM writes it implies.
   function automatic int model_write(input logic [7:0] attr, input logic [7:0] ch);
      int n = 0;
      int idx;
      bit past = 1'b0;
      if (ch == 8'h0A) begin
         if (mr == ROWS - 1) past = 1'b1;
         mc = 0;
         mr = (mr + 1) % ROWS;
      end else if (ch == 8'h0D) begin
         mc = 0;
      end else begin
         exp_mem[mr * COLS + mc] = {attr, ch};
         n   = 1;
         idx = mr * COLS + mc + 1;
         if (idx == CELLS) past = 1'b1;
         idx = idx % CELLS;
         mc  = idx % COLS;
         mr  = idx / COLS;
      end
      if (past && SCROLL) begin
         for (int a = 0; a < CELLS - COLS; a++) exp_mem[a] = exp_mem[a + COLS];
         for (int a = CELLS - COLS; a < CELLS; a++) exp_mem[a] = 16'h0F20;
         mc = 0;
         mr = ROWS - 1;
         n  = n + CELLS;
      end
      return n;
   endfunction

   task automatic start_op(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1);
      @(negedge phi2);
      instruction = op;
      arg_0 = a0;
      arg_1 = a1;
      instruction_start = 1'b1;
      @(negedge phi2);
      instruction_start = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (instruction_busy && n < limit) begin
         @(negedge phi2);
         n++;
      end
      checks++;
      if (instruction_busy) begin
         errors++;
         $display("FAIL timeout busy=%0d after %0d cycles, required 0", instruction_busy, limit);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      instruction = 8'h00;
      arg_0 = 8'h00;
      arg_1 = 8'h00;
      instruction_start = 1'b0;
      repeat (3) @(negedge phi2);
      checks++;
      if ({instruction_busy, instruction_finished, instruction_error, vram_we, vram_addr, vram_wdata,
           result_0, result_1, cursor_col, cursor_row} !== '0) begin
         errors++;
         $display("FAIL reset_outputs busy=%0d fin=%0d err=%0d we=%0d addr=%0d wdata=%h r0=%h r1=%h col=%0d row=%0d required all 0",
                  instruction_busy, instruction_finished, instruction_error, vram_we, vram_addr, vram_wdata,
                  result_0, result_1, cursor_col, cursor_row);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge phi2);
      checks++;
      if (instruction_busy !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
         errors++;
         $display("FAIL reset_release busy=%0d col=%0d row=%0d required 0,0,0", instruction_busy, cursor_col, cursor_row);
      end
      mc = 0; mr = 0; m_res0 = 8'h00; m_res1 = 8'h00;
      $display("reset: outputs idle, cursor (%0d,%0d)", cursor_col, cursor_row);
   endtask

   task automatic test_write();
      int f0 = fin_total, e0 = err_total, b0 = busy_total, w0 = wa_q.size();
      int nw;
      start_op(8'h00, 8'h1F, 8'h41);
      wait_idle(10);
      @(negedge phi2);
      nw = model_write(8'h1F, 8'h41);
      checks++;
      if (wa_q.size() - w0 != nw || nw != 1) begin
         errors++;
         $display("FAIL write_count got %0d required 1", wa_q.size() - w0);
      end else begin
         checks++;
         if (wa_q[w0] != 0 || wd_q[w0] !== 16'h1F41) begin
            errors++;
            $display("FAIL write_cell got addr=%0d data=%h required addr=0 data=1f41", wa_q[w0], wd_q[w0]);
         end
      end
      checks++;
      if (busy_total - b0 != 2) begin
         errors++;
         $display("FAIL write_busy_len got %0d required 2", busy_total - b0);
      end
      checks++;
      if (fin_total - f0 != 1 || err_total - e0 != 0) begin
         errors++;
         $display("FAIL write_pulses got fin=%0d err=%0d required fin=1 err=0", fin_total - f0, err_total - e0);
      end
      checks++;
      if (cursor_col !== 7'd1 || cursor_row !== 5'd0) begin
         errors++;
         $display("FAIL write_cursor got (%0d,%0d) required (1,0)", cursor_col, cursor_row);
      end
      $display("TEXT_WRITE 1f/41 -> cursor (%0d,%0d)", cursor_col, cursor_row);
   endtask

   task automatic test_wrap();
      int f0, w0, nw;
      start_op(8'h01, 8'd79, 8'd29);
      wait_idle(10);
      mc = 79; mr = 29;
      checks++;
      if (cursor_col !== 7'd79 || cursor_row !== 5'd29) begin
         errors++;
         $display("FAIL position_set got (%0d,%0d) required (79,29)", cursor_col, cursor_row);
      end
      f0 = fin_total;
      w0 = wa_q.size();
      start_op(8'h00, 8'h1F, 8'h42);
      wait_idle(6000);
      @(negedge phi2);
      nw = model_write(8'h1F, 8'h42);
      checks++;
      if (wa_q.size() - w0 != nw) begin
         errors++;
         $display("FAIL wrap_write_count got %0d required %0d", wa_q.size() - w0, nw);
      end else begin
         checks++;
         if (wa_q[w0] != 2399 || wd_q[w0] !== 16'h1F42) begin
            errors++;
            $display("FAIL wrap_write_cell got addr=%0d data=%h required addr=2399 data=1f42", wa_q[w0], wd_q[w0]);
         end
      end
      checks++;
      if (int'(cursor_col) != mc || int'(cursor_row) != mr || fin_total - f0 != 1) begin
         errors++;
         $display("FAIL wrap_cursor got (%0d,%0d) fin=%0d required (%0d,%0d) fin=1",
                  cursor_col, cursor_row, fin_total - f0, mc, mr);
      end
      $display("TEXT_WRITE at (79,29) -> cursor (%0d,%0d)", cursor_col, cursor_row);
   endtask

   task automatic test_errors();
      int f0 = fin_total, e0 = err_total, b0 = busy_total;
      start_op(8'h01, 8'd80, 8'd5);
      wait_idle(10);
      @(negedge phi2);
      checks++;
      if (err_total - e0 != 1 || fin_total - f0 != 0) begin
         errors++;
         $display("FAIL position_err_pulses got err=%0d fin=%0d required err=1 fin=0", err_total - e0, fin_total - f0);
      end
      checks++;
      if (int'(cursor_col) != mc || int'(cursor_row) != mr) begin
         errors++;
         $display("FAIL position_err_cursor got (%0d,%0d) required (%0d,%0d)", cursor_col, cursor_row, mc, mr);
      end
      $display("TEXT_POSITION (80,5) -> error");
      f0 = fin_total; e0 = err_total;
      start_op(8'h03, 8'd3, 8'd40);
      wait_idle(10);
      @(negedge phi2);
      checks++;
      if (err_total - e0 != 1 || fin_total - f0 != 0 || result_0 !== m_res0 || result_1 !== m_res1) begin
         errors++;
         $display("FAIL get_err got err=%0d fin=%0d r0=%h r1=%h required err=1 fin=0 r0=%h r1=%h",
                  err_total - e0, fin_total - f0, result_0, result_1, m_res0, m_res1);
      end
      $display("GET_TEXT_AT (3,40) -> error");
      f0 = fin_total; e0 = err_total; b0 = busy_total;
      start_op(8'h04, 8'd1, 8'd1);
      repeat (3) @(negedge phi2);
      checks++;
      if (busy_total != b0 || fin_total != f0 || err_total != e0) begin
         errors++;
         $display("FAIL unknown_opcode got busy=%0d fin=%0d err=%0d required 0,0,0",
                  busy_total - b0, fin_total - f0, err_total - e0);
      end
      $display("opcode 04 -> ignored");
   endtask

   task automatic test_clear();
      int f0 = fin_total, e0 = err_total, b0 = busy_total, w0 = wa_q.size();
      int n = 0, bad = 0;
      start_op(8'h02, 8'h07, 8'h00);
      while (instruction_busy && n < 3000) begin
         @(negedge phi2);
         n++;
         if (n == 100) begin
            instruction = 8'h01; arg_0 = 8'd5; arg_1 = 8'd5; instruction_start = 1'b1;
         end else if (n == 101) begin
            instruction_start = 1'b0;
         end
      end
      checks++;
      if (instruction_busy) begin
         errors++;
         $display("FAIL clear_timeout busy=%0d required 0", instruction_busy);
      end
      checks++;
      if (busy_total - b0 != CELLS + 1) begin
         errors++;
         $display("FAIL clear_busy_len got %0d required %0d", busy_total - b0, CELLS + 1);
      end
      checks++;
      if (wa_q.size() - w0 != CELLS) begin
         errors++;
         $display("FAIL clear_write_count got %0d required %0d", wa_q.size() - w0, CELLS);
      end else begin
         for (int i = 0; i < CELLS; i++)
            if (wa_q[w0 + i] != i || wd_q[w0 + i] !== 16'h0720) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL clear_cells got %0d bad cells required 0", bad);
         end
      end
      checks++;
      if (fin_total - f0 != 1 || err_total - e0 != 0 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
         errors++;
         $display("FAIL clear_end got fin=%0d err=%0d cursor (%0d,%0d) required fin=1 err=0 (0,0)",
                  fin_total - f0, err_total - e0, cursor_col, cursor_row);
      end
      for (int a = 0; a < CELLS; a++) exp_mem[a] = 16'h0720;
      mc = 0; mr = 0;
      $display("TEXT_CLEAR 07 -> %0d writes, cursor (%0d,%0d)", wa_q.size() - w0, cursor_col, cursor_row);
   endtask

   task automatic test_read();
      int f0, b0, nw;
      start_op(8'h01, 8'd10, 8'd2);
      wait_idle(10);
      mc = 10; mr = 2;
      start_op(8'h00, 8'h3C, 8'h58);
      wait_idle(10);
      nw = model_write(8'h3C, 8'h58);
      f0 = fin_total; b0 = busy_total;
      start_op(8'h03, 8'd10, 8'd2);
      wait_idle(10);
      @(negedge phi2);
      checks++;
      if (result_0 !== 8'h58 || result_1 !== 8'h3C) begin
         errors++;
         $display("FAIL get_result got r0=%h r1=%h required r0=58 r1=3c", result_0, result_1);
      end
      checks++;
      if (fin_total - f0 != 1 || busy_total - b0 != 3 || nw != 1) begin
         errors++;
         $display("FAIL get_timing got fin=%0d busy=%0d required fin=1 busy=3", fin_total - f0, busy_total - b0);
      end
      m_res0 = 8'h58; m_res1 = 8'h3C;
      $display("GET_TEXT_AT (10,2) -> %h/%h", result_1, result_0);
   endtask

   task automatic test_random();
      for (int it = 0; it < 250; it++) begin
         int kind, f0, e0, b0, w0, exp_fin, exp_err, exp_nw, exp_waddr;
         logic [7:0]  op, a0, a1;
         logic [15:0] exp_wdata;
         bit first_ok;
         kind = $urandom_range(0, 9);
         op = 8'h00; a0 = 8'h00; a1 = 8'h00;
         exp_fin = 0; exp_err = 0; exp_nw = 0; exp_waddr = 0; exp_wdata = 16'h0; first_ok = 1'b0;
         if (kind <= 3) begin
            op = 8'h00;
            a0 = 8'($urandom_range(0, 255));
            a1 = (kind == 3) ? (($urandom_range(0, 1) != 0) ? 8'h0A : 8'h0D) : 8'($urandom_range(0, 255));
         end else if (kind <= 6) begin
            op = 8'h01;
            if ($urandom_range(0, 3) == 0) begin
               a0 = 8'(COLS - 1 - int'($urandom_range(0, 1)));
               a1 = 8'(ROWS - 1);
            end else begin
               a0 = 8'($urandom_range(0, 90));
               a1 = 8'($urandom_range(0, 35));
            end
         end else if (kind <= 8) begin
            op = 8'h03;
            a0 = 8'($urandom_range(0, 90));
            a1 = 8'($urandom_range(0, 35));
         end else begin
            op = 8'($urandom_range(4, 255));
         end
         // Expected outcome from the model before issuing the op
         if (op == 8'h00) begin
            exp_waddr = mr * COLS + mc;
            exp_wdata = {a0, a1};
            first_ok  = (a1 != 8'h0A && a1 != 8'h0D);
            exp_nw    = model_write(a0, a1);
            exp_fin   = 1;
         end else if (op == 8'h01 || op == 8'h03) begin
            if (int'(a0) < COLS && int'(a1) < ROWS) begin
               exp_fin = 1;
               if (op == 8'h01) begin
                  mc = int'(a0); mr = int'(a1);
               end else begin
                  m_res0 = exp_mem[int'(a1) * COLS + int'(a0)][7:0];
                  m_res1 = exp_mem[int'(a1) * COLS + int'(a0)][15:8];
               end
            end else begin
               exp_err = 1;
            end
         end
         f0 = fin_total; e0 = err_total; b0 = busy_total; w0 = wa_q.size();
         start_op(op, a0, a1);
         wait_idle(6000);
         @(negedge phi2);
         checks++;
         if (fin_total - f0 != exp_fin || err_total - e0 != exp_err) begin
            errors++;
            $display("FAIL rnd_pulses op=%h a0=%h a1=%h got fin=%0d err=%0d required fin=%0d err=%0d",
                     op, a0, a1, fin_total - f0, err_total - e0, exp_fin, exp_err);
         end
         checks++;
         if (wa_q.size() - w0 != exp_nw) begin
            errors++;
            $display("FAIL rnd_write_count op=%h got %0d required %0d", op, wa_q.size() - w0, exp_nw);
         end else if (first_ok) begin
            checks++;
            if (wa_q[w0] != exp_waddr || wd_q[w0] !== exp_wdata) begin
               errors++;
               $display("FAIL rnd_write_cell got addr=%0d data=%h required addr=%0d data=%h",
                        wa_q[w0], wd_q[w0], exp_waddr, exp_wdata);
            end
         end
         checks++;
         if (int'(cursor_col) != mc || int'(cursor_row) != mr) begin
            errors++;
            $display("FAIL rnd_cursor op=%h got (%0d,%0d) required (%0d,%0d)", op, cursor_col, cursor_row, mc, mr);
         end
         checks++;
         if (result_0 !== m_res0 || result_1 !== m_res1) begin
            errors++;
            $display("FAIL rnd_results op=%h got r0=%h r1=%h required r0=%h r1=%h",
                     op, result_0, result_1, m_res0, m_res1);
         end
         if (exp_fin == 0 && exp_err == 0) begin
            checks++;
            if (busy_total != b0) begin
               errors++;
               $display("FAIL rnd_ignored_busy op=%h got %0d busy cycles required 0", op, busy_total - b0);
            end
         end
         $display("rnd %0d op=%h a0=%h a1=%h fin=%0d err=%0d cursor (%0d,%0d)",
                  it, op, a0, a1, fin_total - f0, err_total - e0, cursor_col, cursor_row);
      end
      checks++;
      if (both_total != 0) begin
         errors++;
         $display("FAIL fin_err_overlap got %0d cycles required 0", both_total);
      end
   endtask

   task automatic test_reset_midclear();
      int w0 = wa_q.size();
      start_op(8'h02, 8'h5A, 8'h00);
      repeat (40) @(negedge phi2);
      @(posedge phi2);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (vram_we !== 1'b0 || instruction_busy !== 1'b0) begin
         errors++;
         $display("FAIL midclear_abort got we=%0d busy=%0d required 0,0", vram_we, instruction_busy);
      end
      checks++;
      if ({instruction_finished, instruction_error, vram_addr, vram_wdata, result_0, result_1,
           cursor_col, cursor_row} !== '0) begin
         errors++;
         $display("FAIL midclear_outputs got addr=%0d wdata=%h r0=%h r1=%h col=%0d row=%0d required all 0",
                  vram_addr, vram_wdata, result_0, result_1, cursor_col, cursor_row);
      end
      checks++;
      if (wa_q.size() - w0 != 41) begin
         errors++;
         $display("FAIL midclear_writes got %0d required 41", wa_q.size() - w0);
      end
      for (int a = 0; a <= 40; a++) exp_mem[a] = 16'h5A20;
      mc = 0; mr = 0; m_res0 = 8'h00; m_res1 = 8'h00;
      @(negedge phi2);
      @(negedge phi2);
      reset_n = 1'b1;
      $display("reset during TEXT_CLEAR -> aborted after 41 cells");
      for (int c = 40; c <= 41; c++) begin
         start_op(8'h03, 8'(c), 8'd0);
         wait_idle(10);
         @(negedge phi2);
         checks++;
         if (result_0 !== exp_mem[c][7:0] || result_1 !== exp_mem[c][15:8]) begin
            errors++;
            $display("FAIL partial_clear_cell%0d got %h%h required %h", c, result_1, result_0, exp_mem[c]);
         end
         $display("GET_TEXT_AT (%0d,0) -> %h/%h", c, result_1, result_0);
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      fin_total = 0; err_total = 0; busy_total = 0; both_total = 0;
      test_reset();
      test_write();
      test_wrap();
      test_errors();
      test_clear();
      test_read();
      test_random();
      test_reset_midclear();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
